// File: rtl/monopix_rx_core.sv
// MONOPIX token readout controller: FREEZE/READ sequencing, serial hit deserialiser,
// and a first-word-fall-through hit FIFO with lost-hit accounting.
module monopix_rx_core #(
    parameter int         DATA_BITS  = 24,
    parameter int         FREEZE_DLY = 4,
    parameter int         READ_WIDTH = 2,
    parameter int         READ_GAP   = 2,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [3:0] IDENTIFIER = 4'b0001
) (
    input  logic        CLK,
    input  logic        RST_B,
    input  logic        ENABLE,
    input  logic        TOKEN,
    input  logic        DATA,
    output logic        FREEZE,
    output logic        READ,
    input  logic        FIFO_READ,
    output logic        FIFO_EMPTY,
    output logic [31:0] FIFO_DATA,
    output logic [7:0]  LOST_CNT,
    output logic        BUSY
);

    // state    | meaning
    // IDLE     | waiting for synchronised TOKEN with ENABLE
    // FRZ      | FREEZE settling delay before the first read
    // RD       | READ strobe high for one hit
    // GAP      | READ low, waiting for chip data to appear
    // SHIFT    | sampling DATA, MSB first
    // STORE    | push hit word; loop to RD while TOKEN persists
    // UNFRZ    | FREEZE released for one cycle before IDLE
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FRZ   = 3'd1;
    localparam logic [2:0] ST_RD    = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_SHIFT = 3'd4;
    localparam logic [2:0] ST_STORE = 3'd5;
    localparam logic [2:0] ST_UNFRZ = 3'd6;

    localparam int          AW    = $clog2(FIFO_DEPTH);
    localparam logic [27:0] DMASK = 28'((29'd1 << DATA_BITS) - 29'd1);

    logic [2:0]  state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        tok_meta, tok_s;
    logic [27:0] shreg;
    logic [31:0] word;
    logic [31:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, push_req, push, pop;
    logic [7:0]  lost_cnt;

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            tok_meta <= 1'b0;
            tok_s    <= 1'b0;
        end else begin
            tok_meta <= TOKEN;
            tok_s    <= tok_meta;
        end
    end

    // cnt is a down-counter loaded with (length - 1) on entry to each timed state
    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt != 8'd0) ? cnt - 8'd1 : 8'd0;
        case (state)
            ST_IDLE: begin
                if (tok_s && ENABLE) begin
                    state_nxt = ST_FRZ;
                    cnt_nxt   = 8'(FREEZE_DLY - 1);
                end
            end
            ST_FRZ: begin
                if (cnt == 8'd0) begin
                    state_nxt = ST_RD;
                    cnt_nxt   = 8'(READ_WIDTH - 1);
                end
            end
            ST_RD: begin
                if (cnt == 8'd0) begin
                    if (READ_GAP == 0) begin
                        state_nxt = ST_SHIFT;
                        cnt_nxt   = 8'(DATA_BITS - 1);
                    end else begin
                        state_nxt = ST_GAP;
                        cnt_nxt   = 8'(READ_GAP - 1);
                    end
                end
            end
            ST_GAP: begin
                if (cnt == 8'd0) begin
                    state_nxt = ST_SHIFT;
                    cnt_nxt   = 8'(DATA_BITS - 1);
                end
            end
            ST_SHIFT: begin
                if (cnt == 8'd0) state_nxt = ST_STORE;
            end
            ST_STORE: begin
                if (tok_s) begin
                    state_nxt = ST_RD;
                    cnt_nxt   = 8'(READ_WIDTH - 1);
                end else begin
                    state_nxt = ST_UNFRZ;
                end
            end
            ST_UNFRZ: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state <= ST_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Stale bits from earlier hits shift up past DATA_BITS and are masked off below
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            shreg <= 28'd0;
        end else if (state == ST_SHIFT) begin
            shreg <= {shreg[26:0], DATA};
        end
    end

    assign word = {IDENTIFIER, shreg & DMASK};

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = FIFO_READ && !empty;
    assign push_req = (state == ST_STORE);
    assign push     = push_req && (!full || pop);

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            lost_cnt <= 8'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            if (push_req && full && !pop && lost_cnt != 8'hFF) lost_cnt <= lost_cnt + 8'd1;
        end
    end

    // When full with a pop, the write lands on the slot being read out this cycle
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr[AW-1:0]] <= word;
    end

    assign FIFO_EMPTY = empty;
    assign FIFO_DATA  = empty ? 32'd0 : mem[rd_ptr[AW-1:0]];
    assign LOST_CNT   = lost_cnt;
    assign FREEZE     = (state == ST_FRZ) || (state == ST_RD) || (state == ST_GAP) ||
                        (state == ST_SHIFT) || (state == ST_STORE);
    assign READ       = (state == ST_RD);
    assign BUSY       = (state != ST_IDLE);

endmodule

// File: tb/tb_monopix_rx_core.sv
// Bench for monopix_rx_core: four instances (default, shallow FIFO, 1-bit, 28-bit) driven
// by a chip model that serialises queued hit words, with a per-cycle FIFO/lost-count model.
module tb_monopix_rx_core;
    localparam int N  = 4;
    localparam int RW = 2;

    function automatic int p_db(input int g);
        return (g == 2) ? 1 : (g == 3) ? 28 : 24;
    endfunction
    function automatic int p_rg(input int g);
        return (g == 2) ? 0 : 2;
    endfunction
    function automatic int p_depth(input int g);
        return (g == 1) ? 4 : 16;
    endfunction

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        rstb [N];
    logic        en   [N];
    logic        tok  [N];
    logic        dat  [N];
    logic        frd  [N];
    logic        frz  [N];
    logic        rd   [N];
    logic        emp  [N];
    logic        busy [N];
    logic [31:0] fdat [N];
    logic [7:0]  lost [N];

    int tests = 0;
    int fails = 0;

    // model state
    logic [27:0] hd     [N][16];
    int          hd_wr  [N] = '{default: 0};
    int          hd_rd  [N] = '{default: 0};
    logic [31:0] mq     [N][16];
    int          mcnt   [N] = '{default: 0};
    int          mlost  [N] = '{default: 0};
    bit          act_c  [N] = '{default: 0};
    int          k_c    [N] = '{default: 0};
    logic        prev_rd[N] = '{default: 1'b0};
    logic [27:0] cur_w  [N] = '{default: 28'd0};

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            monopix_rx_core #(
                .DATA_BITS (p_db(g)),
                .READ_GAP  (p_rg(g)),
                .FIFO_DEPTH(p_depth(g))
            ) u_dut (
                .CLK       (CLK),
                .RST_B     (rstb[g]),
                .ENABLE    (en[g]),
                .TOKEN     (tok[g]),
                .DATA      (dat[g]),
                .FREEZE    (frz[g]),
                .READ      (rd[g]),
                .FIFO_READ (frd[g]),
                .FIFO_EMPTY(emp[g]),
                .FIFO_DATA (fdat[g]),
                .LOST_CNT  (lost[g]),
                .BUSY      (busy[g])
            );
        end
    endgenerate

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_hit(input int i, input logic [27:0] w);
        hd[i][hd_wr[i] % 16] = w;
        hd_wr[i]++;
    endtask

    task automatic pop_expect(input int i, input string name, input logic [31:0] exp);
        check(name, fdat[i], exp);
        frd[i] = 1'b1;
        tick();
        frd[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input string name);
        for (int n = 0; n < 400 && busy[i]; n++) tick();
        check(name, 32'(busy[i]), 32'd0);
    endtask

    task automatic wait_rise(input int i, input string name);
        logic pr;
        bit   seen;
        seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            pr = rd[i];
            tick();
            seen = rd[i] && !pr;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    // Holds TOKEN until the nh-th READ rise, then lets the frame drain.
    task automatic run_frame(input int i, input int nh, input string name,
                             output int sp_first, output int sp_last);
        logic pr;
        int   rises, cyc, t_prev;
        bit   bad;
        rises = 0; cyc = 0; t_prev = 0; bad = 1'b0; sp_first = 0; sp_last = 0;
        tok[i] = 1'b1;
        pr = rd[i];
        for (int n = 0; n < 600; n++) begin
            tick();
            cyc++;
            if (rd[i] && !pr) begin
                rises++;
                if (rises == 2) sp_first = cyc - t_prev;
                if (rises >= 2) sp_last = cyc - t_prev;
                t_prev = cyc;
                if (rises == nh) tok[i] = 1'b0;
            end
            pr = rd[i];
            if (rises > 0 && rises < nh && !frz[i]) bad = 1'b1;
            if (rises >= nh && !busy[i]) break;
        end
        check({name, "_hits"}, 32'(rises), 32'(nh));
        check({name, "_freeze_held"}, 32'(bad), 32'd0);
        check({name, "_idle"}, 32'(busy[i]), 32'd0);
    endtask

    task automatic single_hit(input int i);
        push_hit(i, 28'hA5A5A5);
        tok[i] = 1'b1;
        tick(); tick();
        check("sh_freeze_before", 32'(frz[i]), 32'd0);
        tick();
        check("sh_freeze_rise", 32'(frz[i]), 32'd1);
        check("sh_busy", 32'(busy[i]), 32'd1);
        tick(); tick(); tick();
        check("sh_read_before", 32'(rd[i]), 32'd0);
        tick();
        check("sh_read_rise", 32'(rd[i]), 32'd1);
        repeat (6) tick();
        tok[i] = 1'b0;
        for (int n = 0; n < 100 && frz[i]; n++) tick();
        check("sh_unfrz_busy", 32'(busy[i]), 32'd1);
        check("sh_word", fdat[i], 32'h10A5A5A5);
        tick();
        check("sh_idle", 32'(busy[i]), 32'd0);
        pop_expect(i, "sh_pop", 32'h10A5A5A5);
        check("sh_empty", 32'(emp[i]), 32'd1);
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge CLK);
            for (int i = 0; i < N; i++) begin
                int          db, base;
                bit          store, pop, full;
                logic [28:0] m;
                db    = p_db(i);
                base  = RW + p_rg(i);
                store = 1'b0;
                m     = (29'd1 << db) - 29'd1;
                if (!rstb[i]) begin
                    check("reset_ctl", {29'd0, frz[i], rd[i], busy[i]}, 32'd0);
                    check("reset_empty", 32'(emp[i]), 32'd1);
                    check("reset_data", fdat[i], 32'd0);
                    check("reset_lost", 32'(lost[i]), 32'd0);
                    mcnt[i] = 0; mlost[i] = 0; act_c[i] = 1'b0; prev_rd[i] = 1'b0; dat[i] = 1'b0;
                end else begin
                    check("empty", 32'(emp[i]), 32'(mcnt[i] == 0));
                    if (mcnt[i] != 0) check("head", fdat[i], mq[i][0]);
                    check("lost", 32'(lost[i]), 32'(mlost[i]));
                    check("read_in_freeze", 32'(rd[i] & ~frz[i]), 32'd0);
                    check("freeze_busy", 32'(frz[i] & ~busy[i]), 32'd0);
                    // chip side: a READ rise starts a new hit, bits appear after READ and gap
                    if (rd[i] && !prev_rd[i]) begin
                        act_c[i] = 1'b1;
                        k_c[i]   = 0;
                        if (hd_rd[i] < hd_wr[i]) begin
                            cur_w[i] = hd[i][hd_rd[i] % 16];
                            hd_rd[i]++;
                        end else begin
                            cur_w[i] = 28'd0;
                        end
                    end else if (act_c[i]) begin
                        k_c[i]++;
                    end
                    prev_rd[i] = rd[i];
                    dat[i] = 1'b0;
                    if (act_c[i]) begin
                        if (k_c[i] >= base && k_c[i] < base + db)
                            dat[i] = cur_w[i][db - 1 - (k_c[i] - base)];
                        if (k_c[i] == base + db) begin
                            store    = 1'b1;
                            act_c[i] = 1'b0;
                        end
                    end
                    // FIFO effect of the coming edge
                    pop  = frd[i] && (mcnt[i] > 0);
                    full = (mcnt[i] == p_depth(i));
                    if (pop) begin
                        for (int j = 0; j < 15; j++) mq[i][j] = mq[i][j+1];
                        mcnt[i]--;
                    end
                    if (store) begin
                        if (!full || pop) begin
                            mq[i][mcnt[i]] = {4'h1, cur_w[i] & m[27:0]};
                            mcnt[i]++;
                        end else if (mlost[i] < 255) begin
                            mlost[i]++;
                        end
                    end
                end
            end
        end
    endtask

    task automatic stimulus();
        int  s0, s1;
        bit  bad;
        tick(); tick();
        for (int i = 0; i < N; i++) rstb[i] = 1'b1;
        tick();

        // default instance: single hit, multi-hit, reset mid-shift, enable gating
        single_hit(0);

        push_hit(0, 28'h000001); push_hit(0, 28'h000002); push_hit(0, 28'h000003);
        run_frame(0, 3, "multi", s0, s1);
        check("multi_spacing_1", 32'(s0), 32'd29);
        check("multi_spacing_2", 32'(s1), 32'd29);
        pop_expect(0, "multi_w0", 32'h10000001);
        pop_expect(0, "multi_w1", 32'h10000002);
        check("multi_w2", fdat[0], 32'h10000003);

        push_hit(0, 28'hA5A5A5);
        tok[0] = 1'b1;
        wait_rise(0, "rst_read_rise");
        repeat (14) tick();
        check("rst_in_shift", {30'd0, frz[0], rd[0]}, 32'd2);
        rstb[0] = 1'b0;
        #1;
        check("rst_async_ctl", {29'd0, frz[0], rd[0], busy[0]}, 32'd0);
        check("rst_async_empty", 32'(emp[0]), 32'd1);
        check("rst_async_data", fdat[0], 32'd0);
        tok[0] = 1'b0;
        tick(); tick();
        rstb[0] = 1'b1;
        repeat (3) tick();
        check("rst_no_push", 32'(emp[0]), 32'd1);
        single_hit(0);

        en[0] = 1'b0;
        tok[0] = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            tick();
            if (frz[0] || busy[0]) bad = 1'b1;
        end
        check("en_off_stays_idle", 32'(bad), 32'd0);
        tok[0] = 1'b0;
        repeat (4) tick();
        en[0] = 1'b1;
        push_hit(0, 28'h5A5A5A);
        tok[0] = 1'b1;
        for (int n = 0; n < 20 && !frz[0]; n++) tick();
        check("en_frame_start", 32'(frz[0]), 32'd1);
        en[0] = 1'b0;
        wait_rise(0, "en_read_rise");
        tok[0] = 1'b0;
        wait_idle(0, "en_frame_done");
        check("en_word", fdat[0], 32'h105A5A5A);
        tok[0] = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            tick();
            if (busy[0]) bad = 1'b1;
        end
        check("en_no_new_frame", 32'(bad), 32'd0);
        tok[0] = 1'b0;
        pop_expect(0, "en_pop", 32'h105A5A5A);
        en[0] = 1'b1;

        // depth-4 instance: overflow and push-while-full-with-pop
        for (int j = 0; j < 6; j++) push_hit(1, 28'h11 + 28'(j));
        run_frame(1, 6, "ovf", s0, s1);
        check("ovf_lost", 32'(lost[1]), 32'd2);
        check("ovf_head", fdat[1], 32'h10000011);
        push_hit(1, 28'h17);
        tok[1] = 1'b1;
        wait_rise(1, "ovf7_read_rise");
        tok[1] = 1'b0;
        repeat (28) tick();
        check("ovf7_store", {29'd0, frz[1], rd[1], busy[1]}, 32'd5);
        frd[1] = 1'b1;
        tick();
        frd[1] = 1'b0;
        check("ovf7_lost", 32'(lost[1]), 32'd2);
        check("ovf7_head", fdat[1], 32'h10000012);
        wait_idle(1, "ovf7_idle");
        pop_expect(1, "ovf_d0", 32'h10000012);
        pop_expect(1, "ovf_d1", 32'h10000013);
        pop_expect(1, "ovf_d2", 32'h10000014);
        pop_expect(1, "ovf_d3", 32'h10000017);
        check("ovf_drained", 32'(emp[1]), 32'd1);

        // 1-bit, no gap: includes a pop on an empty FIFO
        frd[2] = 1'b1;
        tick();
        frd[2] = 1'b0;
        check("db1_empty_pop", 32'(emp[2]), 32'd1);
        push_hit(2, 28'd1); push_hit(2, 28'd0);
        run_frame(2, 2, "db1", s0, s1);
        check("db1_spacing", 32'(s0), 32'd4);
        pop_expect(2, "db1_w0", 32'h10000001);
        pop_expect(2, "db1_w1", 32'h10000000);
        check("db1_empty", 32'(emp[2]), 32'd1);

        // 28-bit: no pad bits
        push_hit(3, 28'hABCDEF5);
        run_frame(3, 1, "db28", s0, s1);
        pop_expect(3, "db28_w0", 32'h1ABCDEF5);
        check("db28_empty", 32'(emp[3]), 32'd1);
        repeat (3) tick();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            rstb[i] = 1'b0;
            en[i]   = 1'b1;
            tok[i]  = 1'b0;
            frd[i]  = 1'b0;
            dat[i]  = 1'b0;
        end
        fork
            compare_loop();
            stimulus();
        join_any
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
